// File: rtl/bkm_stim_pkg.sv
// Shared definitions for the bkm_steps stimulus sequencer: FSM encoding,
// LFSR tap masks, mode_cfg encodings and the Galois LFSR step function.
package bkm_stim_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_START = ST_START,
        S_WAIT  = ST_WAIT,
        S_GAP   = ST_GAP,
        S_DONE  = ST_DONE
    } stim_state_t;

    // Right-shifting Galois masks: tap n maps to bit n-1.
    localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003; // 32,22,2,1
    localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000; // 64,63,61,60

    localparam logic [1:0] MODE_CFG_ZERO = 2'b00;
    localparam logic [1:0] MODE_CFG_ONE  = 2'b01;
    localparam logic [1:0] MODE_CFG_ALT  = 2'b10;

    // Narrower LFSRs are zero-extended in and truncated out; the zero upper
    // bits shift in as zeros, so one 64-bit step serves both widths.
    function automatic logic [63:0] lfsr_step(input logic [63:0] q, input logic [63:0] taps);
        return {1'b0, q[63:1]} ^ (q[0] ? taps : 64'd0);
    endfunction

endpackage

// File: rtl/bkm_steps_stim_lfsr.sv
// Galois LFSR operand source; reloads SEED only on arst_n or srst so that
// successive runs continue the same sequence.
module bkm_lfsr
    import bkm_stim_pkg::*;
#(
    parameter int            WD   = 64,
    parameter logic [WD-1:0] SEED = 1,
    parameter logic [WD-1:0] TAPS = '1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          srst,
    input  logic          step,
    output logic [WD-1:0] q
);

    // An all-zero state would lock up the register.
    localparam logic [WD-1:0] SEED_EFF = (SEED == '0) ? WD'(1) : SEED;

    logic [WD-1:0] q_reg;
    logic [WD-1:0] q_next;

    always_comb begin
        q_next = WD'(lfsr_step(64'(q_reg), 64'(TAPS)));
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q_reg <= SEED_EFF;
        end else if (srst) begin
            q_reg <= SEED_EFF;
        end else if (step) begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/bkm_steps_stim.sv
// Stimulus sequencer for the bkm_steps start/done handshake. Optional WAIT
// watchdog and timeout_err are built only when BKM_STIM_TIMEOUT_EN is defined.
module bkm_steps_stim
    import bkm_stim_pkg::*;
#(
    parameter int            WD         = 64,
    parameter int            N_VECTORS  = 256,
    parameter int            GAP_CYCLES = 2,
    parameter int            TIMEOUT    = 1024,
    parameter logic [WD-1:0] SEED       = 1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          srst,
    input  logic          enable,
    input  logic          go,
    input  logic [1:0]    mode_cfg,
    input  logic [1:0]    format_cfg,
    input  logic          res_done,
    output logic          dut_start,
    output logic          dut_mode,
    output logic [1:0]    dut_format,
    output logic [WD-1:0] dut_u_in,
    output logic [WD-1:0] dut_v_in,
    output logic [WD-1:0] dut_X_in,
    output logic [WD-1:0] dut_Y_in,
    output logic [15:0]   vec_cnt,
    output logic          busy,
    output logic          finished,
    output logic          timeout_err
);

    localparam logic [WD-1:0] TAPS  = (WD == 32) ? WD'(TAPS_32) : WD'(TAPS_64);
    localparam int            GAP_W = $clog2(GAP_CYCLES) + 1;

    stim_state_t          state_reg, state_next;
    logic [1:0]           load_idx_reg;
    logic [GAP_W-1:0]     gap_cnt_reg;
    logic [15:0]          vec_cnt_reg;
    logic [1:0]           format_reg;
    logic                 mode_reg;
    logic                 toggle_reg;
    logic                 start_reg;
    logic [3:0][WD-1:0]   operand;
    logic [WD-1:0]        lfsr_q;
    logic [WD-1:0]        lfsr_next;
    logic                 go_ok;
    logic                 gap_end;
    logic                 more_vectors;
    logic                 load_last;
    logic                 enter_load;
    logic                 wait_expired;

    bkm_lfsr #(
        .WD   (WD),
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk    (clk),
        .arst_n (arst_n),
        .srst   (srst),
        .step   (enable && (state_reg == S_LOAD)),
        .q      (lfsr_q)
    );

    // Operands take the post-step value, i.e. what the LFSR holds after this edge.
    assign lfsr_next = WD'(lfsr_step(64'(lfsr_q), 64'(TAPS)));

    assign go_ok        = go && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign gap_end      = (state_reg == S_GAP) && (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));
    assign more_vectors = (vec_cnt_reg < 16'(N_VECTORS));
    assign load_last    = (state_reg == S_LOAD) && (load_idx_reg == 2'd3);
    assign enter_load   = (state_next == S_LOAD) && (state_reg != S_LOAD);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: if (go) state_next = S_LOAD;
            S_LOAD:         if (load_last) state_next = S_START;
            S_START:        state_next = S_WAIT;
            S_WAIT: begin
                // done wins over a watchdog expiry in the same cycle
                if (res_done)          state_next = S_GAP;
                else if (wait_expired) state_next = S_DONE;
            end
            S_GAP:          if (gap_end) state_next = more_vectors ? S_LOAD : S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg    <= S_IDLE;
            load_idx_reg <= '0;
            gap_cnt_reg  <= '0;
            vec_cnt_reg  <= '0;
            format_reg   <= '0;
            mode_reg     <= 1'b0;
            toggle_reg   <= 1'b0;
            start_reg    <= 1'b0;
        end else if (srst) begin
            state_reg    <= S_IDLE;
            load_idx_reg <= '0;
            gap_cnt_reg  <= '0;
            vec_cnt_reg  <= '0;
            format_reg   <= '0;
            mode_reg     <= 1'b0;
            toggle_reg   <= 1'b0;
            start_reg    <= 1'b0;
        end else if (enable) begin
            state_reg    <= state_next;
            start_reg    <= (state_next == S_START);
            load_idx_reg <= (state_reg == S_LOAD) ? load_idx_reg + 2'd1 : 2'd0;
            gap_cnt_reg  <= (state_reg == S_GAP) ? gap_cnt_reg + GAP_W'(1) : '0;
            if (go_ok) begin
                format_reg  <= format_cfg;
                vec_cnt_reg <= '0;
                toggle_reg  <= 1'b0;
            end
            if (load_last) begin
                vec_cnt_reg <= vec_cnt_reg + 16'd1;
            end
            if (state_reg == S_START) begin
                toggle_reg <= ~toggle_reg;
            end
            if (enter_load) begin
                case (mode_cfg)
                    MODE_CFG_ZERO: mode_reg <= 1'b0;
                    MODE_CFG_ONE:  mode_reg <= 1'b1;
                    default:       mode_reg <= go_ok ? 1'b0 : toggle_reg;
                endcase
            end
        end
    end

    // One register per operand slot, written in LOAD order u, v, X, Y.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_operand
            logic [WD-1:0] op_reg;
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    op_reg <= '0;
                end else if (srst) begin
                    op_reg <= '0;
                end else if (enable && (state_reg == S_LOAD) && (load_idx_reg == 2'(gi))) begin
                    op_reg <= lfsr_next;
                end
            end
            assign operand[gi] = op_reg;
        end
    endgenerate

`ifdef BKM_STIM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timeout_reg;

    // Counts from the START cycle, so expiry lands TIMEOUT cycles after start.
    assign wait_expired = (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (srst) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (enable) begin
            wait_cnt_reg <= ((state_reg == S_START) || (state_reg == S_WAIT)) ?
                            wait_cnt_reg + WAIT_W'(1) : '0;
            if (go_ok) begin
                timeout_reg <= 1'b0;
            end else if ((state_reg == S_WAIT) && !res_done && wait_expired) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_reg;
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    assign dut_start  = start_reg;
    assign dut_mode   = mode_reg;
    assign dut_format = format_reg;
    assign dut_u_in   = operand[0];
    assign dut_v_in   = operand[1];
    assign dut_X_in   = operand[2];
    assign dut_Y_in   = operand[3];
    assign vec_cnt    = vec_cnt_reg;
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign finished   = (state_reg == S_DONE);

endmodule

// File: doc/bkm_steps_stim.md
# bkm_steps_stim

Stimulus sequencer driving the initiator side of the bkm_steps start/done handshake. It generates pseudo-random operand vectors from an LFSR and pulses start to the DUT and to the bkm_steps checker. It then waits for the DUT's done, inserts an inter-vector gap, and repeats for a programmed number of vectors. It sits in the bkm_steps testbench opposite the checker, which consumes the same start/done pair.

## Interface
Parameters:
- WD, 64: operand width in bits; supported values are 32 and 64.
- N_VECTORS, 256: number of vectors per run; valid range 1 to 65535.
- GAP_CYCLES, 2: idle cycles between done and the next vector; minimum 1.
- TIMEOUT, 1024: maximum cycles spent in WAIT before an error is flagged.
- SEED, 1: initial LFSR value; a value of 0 is replaced by 1.

Ports:
- clk, in, 1: the single clock; all logic is on the rising edge.
- arst_n, in, 1: asynchronous reset, active-low.
- srst, in, 1: synchronous clear, active-high; has priority over enable.
- enable, in, 1: clock enable; when low, all state freezes.
- go, in, 1: run request; sampled only in IDLE and DONE.
- mode_cfg, in, 2: mode selection. 00 = mode always 0; 01 = mode always 1; 1x = mode alternates, starting at 0.
- format_cfg, in, 2: format value, latched on go.
- res_done, in, 1: DUT done; sampled only in WAIT.
- dut_start, out, 1: start pulse to the DUT and the checker (tb_start).
- dut_mode, out, 1: mode for the current vector.
- dut_format, out, 2: latched format_cfg.
- dut_u_in, dut_v_in, dut_X_in, dut_Y_in, out, WD each: the operands.
- vec_cnt, out, 16: number of vectors issued in this run.
- busy, out, 1: high in every state except IDLE and DONE.
- finished, out, 1: high while in DONE.
- timeout_err, out, 1: sticky error; cleared on go.

## Operation
- FSM states: IDLE, LOAD, START, WAIT, GAP, DONE.
- IDLE → LOAD on go.
  - Latches format_cfg.
  - Clears vec_cnt, timeout_err and the mode toggle.
- LOAD lasts exactly 4 cycles, tracked by a 2-bit index.
  - Each cycle the LFSR steps once.
  - The post-step value is written to u, v, X, Y in that order.
  - LOAD → START.
- START lasts 1 cycle.
  - dut_start = 1.
  - vec_cnt increments.
  - START → WAIT.
- WAIT has two exits:
  - res_done = 1 → GAP.
  - If the wait counter reaches TIMEOUT-1 without done → timeout_err set, then → DONE.
- GAP lasts GAP_CYCLES cycles. It then goes to LOAD if vec_cnt < N_VECTORS, otherwise to DONE.
- DONE holds finished = 1. go → LOAD, with the same latching as from IDLE. DONE is the restart point.
- LFSR: Galois form, WD bits. The polynomial comes from the package: 32-bit taps 32,22,2,1; 64-bit taps 64,63,61,60.
  - The LFSR is never reset between runs, so a restart continues the sequence.
  - Only arst_n and srst reload SEED.
- dut_mode:
  - mode_cfg 00 → 0; 01 → 1.
  - mode_cfg 1x → toggles after each START.
  - Updated when entering LOAD.
- Operands and mode are stable from the end of LOAD until the next LOAD. This covers the whole START/WAIT window.
- go is ignored while busy. A res_done outside WAIT is ignored.

## Timing
- Reset (arst_n low, or srst): state = IDLE, LFSR = SEED, all outputs 0.
- Latency:
  - go sampled at edge 0 → LOAD on cycles 1–4 → dut_start high on cycle 5.
  - res_done sampled at edge k → GAP for cycles k+1 … k+GAP_CYCLES → next LOAD.
- dut_start is registered and is exactly 1 cycle wide when enable is high.
- enable low freezes the FSM, LFSR, counters and outputs. If enable drops during START, dut_start stays high until enable returns.
- res_done in the same cycle the wait counter hits its limit: done wins, and timeout_err is not set.
- arst_n asserted mid-run:
  - All outputs clear immediately.
  - The FSM returns to IDLE.
  - No partial vector is resumed.
- With N_VECTORS = 1 there is a single START, then GAP, then DONE.

## Configuration
- BKM_STIM_TIMEOUT_EN
  - Defined: the WAIT watchdog counter and timeout_err exist as described.
  - Undefined: the counter is not synthesized, WAIT waits indefinitely for res_done, and timeout_err is tied to 0.

## Structure
- Shared package bkm_stim_pkg holds:
  - The FSM state encoding, 3 bits, one localparam per state.
  - The LFSR tap masks for WD = 32 and WD = 64.
  - The mode_cfg encodings.
- One sub-module, bkm_lfsr, with parameters WD, SEED and TAPS. Its ports are clk, arst_n, srst, step and q.
- Everything else, including the FSM, counters and operand registers, lives in bkm_steps_stim.

## Test plan
- Basic run. N_VECTORS = 4, GAP_CYCLES = 2. go at cycle 0; the DUT model returns done 10 cycles after each start.
  - Expected: dut_start pulses at cycles 5, 22, 39, 56.
  - finished at cycle 69; vec_cnt = 4.
- Seed check. SEED = 1, WD = 32.
  - Expected: u/v/X/Y equal the first 4 LFSR states computed by a reference model.
  - After a second go, the operands continue the sequence, with no reseed.
- Mode alternation. mode_cfg = 10, N_VECTORS = 3.
  - Expected: dut_mode sequence 0, 1, 0; dut_format equals the value of format_cfg at go, even if format_cfg is changed mid-run.
- Timeout. BKM_STIM_TIMEOUT_EN defined, TIMEOUT = 16, res_done never asserted.
  - Expected: timeout_err = 1 and finished = 1 at start + 16.
  - Repeating with the macro undefined: busy stays high after 1000 cycles.
- Freeze and abort.
  - enable low for 5 cycles during START: dut_start stays high for 6 cycles.
  - arst_n low during WAIT: all outputs are 0 within the reset cycle; a subsequent go restarts from SEED.
